// File: rtl/mips_run_monitor_if.sv
// Sample stream from the run monitor to its consumer.
// The head of the FIFO is presented first-word-fall-through.
interface mips_run_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic                     smp_valid;
  logic                     smp_ready;
  logic [NUM_CH*DATA_W-1:0] smp_data;
  logic [CNT_W-1:0]         smp_cycle;
  logic                     smp_last;

  modport master (
    output smp_valid,
    output smp_data,
    output smp_cycle,
    output smp_last,
    input  smp_ready
  );

  modport slave (
    input  smp_valid,
    input  smp_data,
    input  smp_cycle,
    input  smp_last,
    output smp_ready
  );
endinterface

// File: rtl/mips_run_monitor.sv
// Run controller for the pipelined MIPS top: holds the core in reset, runs it for a bounded
// budget, and periodically snapshots watched datapath values into a sample FIFO.
module mips_run_monitor #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 32,
  parameter int RESET_CYCLES  = 2,
  parameter int SAMPLE_PERIOD = 10,
  parameter int MAX_CYCLES    = 200,
  parameter int FIFO_DEPTH    = 16,
  parameter int PASS_CH       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     expect_en,
  input  logic [DATA_W-1:0]        expect_val,
  output logic                     cpu_rst,
  mips_run_monitor_if.master       smp,
  output logic                     overflow,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout
);
  localparam int CNT_W = $clog2(MAX_CYCLES);
  localparam int PW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int RW    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SW    = NUM_CH * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [RW-1:0]    rcnt;
  logic [PW-1:0]    pcnt;
  logic [CNT_W-1:0] kcnt;

  logic [AW:0]      count;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [SW-1:0]    mem_data  [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_cycle [FIFO_DEPTH];
  logic             mem_last  [FIFO_DEPTH];

  logic match, at_budget, term, push, pop, full, push_ok, start_ok, fifo_nonempty;

  always_comb begin
    match         = expect_en && (ch_data[PASS_CH*DATA_W +: DATA_W] == expect_val);
    at_budget     = (kcnt == CNT_W'(MAX_CYCLES - 1));
    term          = (state == S_RUN) && (match || at_budget);
    push          = (state == S_RUN) && ((pcnt == '0) || term);
    fifo_nonempty = (count != '0);
    pop           = fifo_nonempty && smp.smp_ready;
    full          = (count == (AW+1)'(FIFO_DEPTH));
    // a full FIFO still accepts a push when the head leaves on the same edge
    push_ok       = push && (!full || pop);
    start_ok      = start && ((state == S_IDLE) || (state == S_DONE));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start)                              state_nx = S_RESET;
      S_RESET:        if (rcnt == RW'(RESET_CYCLES - 1))      state_nx = S_RUN;
      S_RUN:          if (term)                               state_nx = S_DRAIN;
      S_DRAIN:        if (!fifo_nonempty)                     state_nx = S_DONE;
      default:                                                state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt     <= '0;
      pcnt     <= '0;
      kcnt     <= '0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else if (start_ok) begin
      rcnt     <= '0;
      pcnt     <= '0;
      kcnt     <= '0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == S_RESET) rcnt <= rcnt + 1'b1;
      if (state == S_RUN) begin
        kcnt <= kcnt + 1'b1;
        pcnt <= (pcnt == PW'(SAMPLE_PERIOD - 1)) ? '0 : pcnt + 1'b1;
        if (term) begin
          pass    <= match;
          timeout <= !match;
        end
      end
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr]  <= ch_data;
      mem_cycle[wr_ptr] <= kcnt;
      mem_last[wr_ptr]  <= term;
    end
  end

  // storage is not reset, so the head is masked until an entry exists
  always_comb begin
    smp.smp_valid = fifo_nonempty;
    smp.smp_data  = fifo_nonempty ? mem_data[rd_ptr]  : '0;
    smp.smp_cycle = fifo_nonempty ? mem_cycle[rd_ptr] : '0;
    smp.smp_last  = fifo_nonempty ? mem_last[rd_ptr]  : 1'b0;
    cpu_rst       = (state == S_IDLE) || (state == S_RESET);
    busy          = (state == S_RESET) || (state == S_RUN) || (state == S_DRAIN);
    done          = (state == S_DONE);
  end
endmodule
